// File: rtl/rgb_frame_sequencer_if.sv
// Pixel source pull handshake plus registered RGB output stream with coordinates and markers.
// The sequencer holds the master side; the source and downstream stages use the slave side.
interface rgb_frame_sequencer_if;
  logic        src_ready;
  logic [7:0]  src_red;
  logic [7:0]  src_green;
  logic [7:0]  src_blue;
  logic        src_rd;

  logic        oValid;
  logic [7:0]  oRed;
  logic [7:0]  oGreen;
  logic [7:0]  oBlue;
  logic [15:0] oXCoord;
  logic [15:0] oYCoord;
  logic        oSof;
  logic        oEol;
  logic        oEof;

  modport master (
    input  src_ready, src_red, src_green, src_blue,
    output src_rd,
    output oValid, oRed, oGreen, oBlue, oXCoord, oYCoord, oSof, oEol, oEof
  );

  modport slave (
    output src_ready, src_red, src_green, src_blue,
    input  src_rd,
    input  oValid, oRed, oGreen, oBlue, oXCoord, oYCoord, oSof, oEol, oEof
  );
endinterface

// File: rtl/rgb_frame_sequencer.sv
// Raster frame sequencer: pulls one pixel per src_rd in ACTIVE, emits it 1 cycle later with x/y and markers.
// src_ready low stalls the raster in place; H/V blanking inserted by a shared down-counter.
module rgb_frame_sequencer #(
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128,
  parameter int HBLANK     = 4,
  parameter int VBLANK     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         continuous,
  rgb_frame_sequencer_if.master        pix,
  output logic                         busy,
  output logic                         frame_done,
  output logic [15:0]                  frame_count
);

  localparam int XW   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [BW-1:0] H_LOAD = BW'(HBLANK - 1);
  localparam logic [BW-1:0] V_LOAD = BW'(VBLANK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLANK,
    S_VBLANK
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic            accept;
  logic            last_x;
  logic            last_y;

  assign last_x = (x_q == X_LAST);
  assign last_y = (y_q == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACTIVE;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_ACTIVE: begin
        accept = pix.src_ready;
        if (accept) begin
          if (!last_x) begin
            x_d = x_q + XW'(1);
          end else if (!last_y) begin
            x_d     = '0;
            y_d     = y_q + YW'(1);
            cnt_d   = H_LOAD;
            state_d = S_HBLANK;
          end else begin
            cnt_d   = V_LOAD;
            state_d = S_VBLANK;
          end
        end
      end
      S_HBLANK: begin
        if (cnt_q == '0) begin
          state_d = S_ACTIVE;
        end else begin
          cnt_d = cnt_q - BW'(1);
        end
      end
      S_VBLANK: begin
        // continuous is only looked at on the final blanking cycle
        if (cnt_q == '0) begin
          x_d     = '0;
          y_d     = '0;
          state_d = continuous ? S_ACTIVE : S_IDLE;
        end else begin
          cnt_d = cnt_q - BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pix.src_rd = accept;
  assign busy       = (state_q != S_IDLE);

  // Coordinates and RGB hold across stalls; markers and valid are per-beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix.oValid  <= 1'b0;
      pix.oRed    <= '0;
      pix.oGreen  <= '0;
      pix.oBlue   <= '0;
      pix.oXCoord <= '0;
      pix.oYCoord <= '0;
      pix.oSof    <= 1'b0;
      pix.oEol    <= 1'b0;
      pix.oEof    <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      pix.oValid <= accept;
      pix.oSof   <= accept && (x_q == '0) && (y_q == '0);
      pix.oEol   <= accept && last_x;
      pix.oEof   <= accept && last_x && last_y;
      frame_done <= accept && last_x && last_y;
      if (accept) begin
        pix.oRed    <= pix.src_red;
        pix.oGreen  <= pix.src_green;
        pix.oBlue   <= pix.src_blue;
        pix.oXCoord <= 16'(x_q);
        pix.oYCoord <= 16'(y_q);
      end
      if (accept && last_x && last_y) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/rgb_frame_sequencer.md
Name: rgb_frame_sequencer

Overview:
- Controls the RGB test datapath: pulls pixels from a pixel source through a ready/read handshake and emits one raster frame.
- Output is a registered valid/R/G/B stream with x/y coordinates and line/frame markers.
- Inserts horizontal and vertical blanking, counts frames, and runs single-shot or continuous.
- Sits between the pixel generator/memory reader and the pixel checker/filter stages.

Parameters:
- IMG_WIDTH, 128, active pixels per line (>=2).
- IMG_HEIGHT, 128, active lines per frame (>=2).
- HBLANK, 4, idle cycles between lines (>=1).
- VBLANK, 8, idle cycles after the last line (>=1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  frame start request; sampled only in IDLE.
- continuous  in  1  1 = start the next frame automatically after VBLANK.
- src_ready  in  1  source has a pixel available.
- src_red / src_green / src_blue  in  8 each  source pixel.
- src_rd  out  1  combinational pop; equals src_ready while in ACTIVE, else 0.
- oValid  out  1  output pixel valid.
- oRed / oGreen / oBlue  out  8 each  output pixel.
- oXCoord / oYCoord  out  16 each  coordinates of the current output pixel.
- oSof / oEol / oEof  out  1 each  first pixel of frame / last pixel of line / last pixel of frame; qualified by oValid.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse per completed frame.
- frame_count  out  16  completed frames; wraps 0xFFFF -> 0.

Behaviour:
- Reset: state IDLE; x=y=0; all outputs 0 on the edge after reset is sampled high. Reset mid-frame aborts the frame: no frame_done, frame_count cleared.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE: start=1 -> ACTIVE next cycle with x=0, y=0.
- ACTIVE:
  - src_rd = src_ready. Each src_rd cycle accepts one pixel.
  - Next cycle: oValid=1, RGB = accepted pixel, oXCoord/oYCoord = x/y at accept time. Latency is exactly 1 cycle.
  - src_ready=0 stalls: oValid=0 next cycle; x/y and RGB outputs hold.
  - Accept with x<W-1: x++.
  - Accept with x==W-1 and y<H-1: x=0, y++, -> HBLANK.
  - Accept with x==W-1 and y==H-1: -> VBLANK.
- HBLANK: src_rd=0 for exactly HBLANK cycles (down-counter), then -> ACTIVE.
- VBLANK:
  - frame_done=1 and frame_count++ in the first VBLANK cycle, coincident with oValid/oEof for the last pixel.
  - After exactly VBLANK cycles: x=y=0; if continuous=1 -> ACTIVE, else -> IDLE.
  - continuous is sampled in the last VBLANK cycle.
- start in any state other than IDLE is ignored. start and reset in the same cycle: reset wins.
- Markers:
  - oSof on pixel (0,0).
  - oEol on pixels with x==W-1.
  - oEof on pixel (W-1,H-1), with oEol also high.
- No pixel is read outside ACTIVE; a pixel is never dropped or duplicated.
- Exactly W*H oValid pulses per frame.
- Counters are sized from the parameters internally; coordinate outputs are zero-extended to 16 bits.

Test Plan (W=4, H=3, HBLANK=2, VBLANK=3 unless noted):
- Reset then start=1 for 1 cycle, src_ready=1 constant, source pattern R=x, G=y, B=x+y -> 12 oValid pulses. oValid pattern: 4 on, 2 off, 4 on, 2 off, 4 on. oSof at (0,0); oEol at x=3; oEof at (3,2). frame_done one cycle with oEof. frame_count=1. IDLE after 3 VBLANK cycles.
- src_ready toggles 1,0,1,0 during line 0 -> src_rd mirrors src_ready only in ACTIVE. oValid gaps match. Coordinates 0,1,2,3 with no skips or repeats. Total still 12 pixels.
- continuous=1, run 3 frames -> busy stays 1. Frame period = 3 VBLANK + 12 active + 4 HBLANK cycles with src_ready=1. frame_count 1,2,3. oSof reappears after each VBLANK.
- Assert reset at pixel (2,1) -> outputs 0 and busy=0 the next cycle. No frame_done. A new start yields a full 12-pixel frame from (0,0).
- Pulse start while in HBLANK and in VBLANK (continuous=0) -> no effect. Exactly one frame, then IDLE.
- Default params, src_ready=1 -> 16384 pixels. Last pixel at (127,127) with oEof. frame_count=1. oValid is never X after reset.
